// File: rtl/heap_array_manager_if.sv
// Request/response bundle between the program sequencer and the heap-array manager.
interface heap_array_manager_if #(
  parameter int WIDTH    = 12,
  parameter int N_ARRAYS = 2,
  parameter int AW       = (N_ARRAYS > 1) ? $clog2(N_ARRAYS) : 1
);
  logic             req;
  logic [2:0]       op;
  logic [AW-1:0]    array;
  logic [WIDTH-1:0] index;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] rdata;
  logic [AW-1:0]    handle;
  logic [AW:0]      in_use;
  logic [AW:0]      peak;

  modport master (output req, op, array, index, wdata,
                  input  busy, done, error, rdata, handle, in_use, peak);
  modport slave  (input  req, op, array, index, wdata,
                  output busy, done, error, rdata, handle, in_use, peak);
endinterface

// File: rtl/heap_array_manager.sv
// Heap-array manager: owns heap storage, per-array lengths, the freed-handle stack and
// the fresh-allocation counter; services one alloc/free/write/read/size request at a time.
module heap_array_manager #(
  parameter int WIDTH    = 12,
  parameter int N_ARRAYS = 2,
  parameter int N_AREA   = 2,
  parameter int AW       = (N_ARRAYS > 1) ? $clog2(N_ARRAYS) : 1,
  parameter int IW       = (N_AREA > 1) ? $clog2(N_AREA) : 1
) (
  input logic                clock,
  input logic                reset,
  heap_array_manager_if.slave bus
);
  localparam int DEPTH = N_ARRAYS * N_AREA;
  localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = WIDTH + IW + 2;

  localparam logic [2:0] OP_ALLOC = 3'd0;
  localparam logic [2:0] OP_FREE  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_SIZE  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, RDWAIT, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    array_q, array_d;
  logic [WIDTH-1:0] index_q, index_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [AW-1:0]    handle_q, handle_d;
  logic             p_err_q, p_err_d;
  logic [WIDTH-1:0] p_rdata_q, p_rdata_d;
  logic [AW-1:0]    p_handle_q, p_handle_d;
  logic [AW:0]      in_use_q, in_use_d;
  logic [AW:0]      peak_q, peak_d;
  logic [N_ARRAYS-1:0] alloc_q, alloc_d;
  logic [IW:0]      len_q [N_ARRAYS];
  logic [IW:0]      len_d [N_ARRAYS];
  logic [AW-1:0]    stack_q [N_ARRAYS];
  logic [AW-1:0]    stack_d [N_ARRAYS];
  logic [AW:0]      sp_q, sp_d;
  logic [AW:0]      fresh_q, fresh_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_rd_q;
  logic             mem_we;

  logic             arr_ok, is_alloc, idx_area, idx_len, can_alloc;
  logic [IW:0]      cur_len, new_len;
  logic [AW-1:0]    new_h;
  logic [MAW-1:0]   addr;

  assign arr_ok    = ({1'b0, array_q} < (AW+1)'(N_ARRAYS));
  assign is_alloc  = arr_ok && alloc_q[array_q];
  assign cur_len   = len_q[array_q];
  // Full-width index compares: a large index must never alias into a valid slot.
  assign idx_area  = CW'(index_q) < CW'(N_AREA);
  assign idx_len   = CW'(index_q) < CW'(cur_len);
  assign new_len   = (IW+1)'(index_q) + (IW+1)'(1);
  assign addr      = MAW'(array_q) * MAW'(N_AREA) + MAW'(index_q);
  assign can_alloc = (sp_q != '0) || (fresh_q < (AW+1)'(N_ARRAYS));
  assign new_h     = (sp_q != '0) ? stack_q[AW'(sp_q - (AW+1)'(1))] : AW'(fresh_q);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    array_d    = array_q;
    index_d    = index_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    error_d    = error_q;
    rdata_d    = rdata_q;
    handle_d   = handle_q;
    p_err_d    = p_err_q;
    p_rdata_d  = p_rdata_q;
    p_handle_d = p_handle_q;
    in_use_d   = in_use_q;
    peak_d     = peak_q;
    alloc_d    = alloc_q;
    len_d      = len_q;
    stack_d    = stack_q;
    sp_d       = sp_q;
    fresh_d    = fresh_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: if (bus.req) begin
        op_d    = bus.op;
        array_d = bus.array;
        index_d = bus.index;
        wdata_d = bus.wdata;
        state_d = EXEC;
      end
      EXEC: begin
        p_err_d    = 1'b0;
        p_rdata_d  = '0;
        p_handle_d = '0;
        state_d    = DONE;
        case (op_q)
          OP_ALLOC: if (!can_alloc) p_err_d = 1'b1;
          else begin
            if (sp_q != '0) sp_d = sp_q - (AW+1)'(1);
            else            fresh_d = fresh_q + (AW+1)'(1);
            alloc_d[new_h] = 1'b1;
            len_d[new_h]   = '0;
            in_use_d       = in_use_q + (AW+1)'(1);
            peak_d         = (in_use_d > peak_q) ? in_use_d : peak_q;
            p_handle_d     = new_h;
          end
          OP_FREE: if (!is_alloc) p_err_d = 1'b1;
          else begin
            alloc_d[array_q]    = 1'b0;
            stack_d[AW'(sp_q)]  = array_q;
            sp_d                = sp_q + (AW+1)'(1);
            in_use_d            = in_use_q - (AW+1)'(1);
          end
          OP_WRITE: if (!is_alloc || !idx_area) p_err_d = 1'b1;
          else begin
            mem_we = 1'b1;
            if (new_len > cur_len) len_d[array_q] = new_len;
          end
          OP_READ: begin
            state_d = RDWAIT;
            if (!is_alloc || !idx_len) p_err_d = 1'b1;
          end
          OP_SIZE: if (!is_alloc) p_err_d = 1'b1;
                   else p_rdata_d = WIDTH'(cur_len);
          default: p_err_d = 1'b1;
        endcase
      end
      RDWAIT: begin
        p_rdata_d = p_err_q ? '0 : mem_rd_q;
        state_d   = DONE;
      end
      DONE: begin
        // Results are published only together with the done pulse.
        done_d   = 1'b1;
        error_d  = p_err_q;
        rdata_d  = p_rdata_q;
        handle_d = p_handle_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= '0;
      array_q    <= '0;
      index_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
      handle_q   <= '0;
      p_err_q    <= 1'b0;
      p_rdata_q  <= '0;
      p_handle_q <= '0;
      in_use_q   <= '0;
      peak_q     <= '0;
      alloc_q    <= '0;
      sp_q       <= '0;
      fresh_q    <= '0;
      for (int i = 0; i < N_ARRAYS; i++) begin
        len_q[i]   <= '0;
        stack_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      array_q    <= array_d;
      index_q    <= index_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rdata_q    <= rdata_d;
      handle_q   <= handle_d;
      p_err_q    <= p_err_d;
      p_rdata_q  <= p_rdata_d;
      p_handle_q <= p_handle_d;
      in_use_q   <= in_use_d;
      peak_q     <= peak_d;
      alloc_q    <= alloc_d;
      sp_q       <= sp_d;
      fresh_q    <= fresh_d;
      len_q      <= len_d;
      stack_q    <= stack_d;
    end
  end

  // Heap storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[addr] <= wdata_q;
    mem_rd_q <= mem[addr];
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.rdata  = rdata_q;
  assign bus.handle = handle_q;
  assign bus.in_use = in_use_q;
  assign bus.peak   = peak_q;
endmodule

// File: tb/tb_heap_array_manager.sv
// Scoreboard bench for heap_array_manager with default parameters (2 arrays x 2 elements).
module tb_heap_array_manager;
  localparam int WIDTH = 12, N_ARRAYS = 2, N_AREA = 2, AW = 1;

  typedef struct {
    logic [2:0]       op;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] idx;
    logic [WIDTH-1:0] wd;
    logic             err;
    logic [WIDTH-1:0] rd;
    logic [AW-1:0]    h;
    int               lat;
  } step_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0, errors = 0;
  step_t sb[$];

  always #5 clock = ~clock;

  heap_array_manager_if #(.WIDTH(WIDTH), .N_ARRAYS(N_ARRAYS)) bus();
  heap_array_manager #(.WIDTH(WIDTH), .N_ARRAYS(N_ARRAYS), .N_AREA(N_AREA))
    dut (.clock(clock), .reset(reset), .bus(bus));

  function automatic step_t mk(input logic [2:0] op, input logic [AW-1:0] a,
                               input int idx, input int wd, input logic err,
                               input int rd, input logic [AW-1:0] h);
    step_t s;
    s.op = op; s.a = a; s.idx = WIDTH'(idx); s.wd = WIDTH'(wd);
    s.err = err; s.rd = WIDTH'(rd); s.h = h;
    s.lat = (op == 3'd3) ? 3 : 2;
    return s;
  endfunction

  // Drives one request, returns the outputs seen with done and edges from acceptance to done.
  task automatic run_req(input step_t s, output logic e, output logic [WIDTH-1:0] rd,
                         output logic [AW-1:0] h, output int lat);
    @(negedge clock);
    bus.req = 1'b1; bus.op = s.op; bus.array = s.a; bus.index = s.idx; bus.wdata = s.wd;
    @(posedge clock); #1;
    bus.req = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 10) begin
      @(posedge clock); #1;
      lat++;
    end
    e = bus.error; rd = bus.rdata; h = bus.handle;
  endtask

  task automatic test_reset;
    bus.req = 1'b0; bus.op = '0; bus.array = '0; bus.index = '0; bus.wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.error, bus.rdata, bus.handle, bus.in_use, bus.peak} !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b error=%b rdata=%0d handle=%0d in_use=%0d peak=%0d, want all 0",
               bus.busy, bus.done, bus.error, bus.rdata, bus.handle, bus.in_use, bus.peak);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    step_t tbl[$];
    step_t x;
    logic e; logic [WIDTH-1:0] rd; logic [AW-1:0] h; int lat;
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 0, 0, 11, 0, 0, 0));
    tbl.push_back(mk(2, 0, 1, 22, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(2, 1, 1, 33, 0, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 33, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 11, 0));
    tbl.push_back(mk(3, 0, 1, 0, 0, 22, 0));
    tbl.push_back(mk(4, 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      run_req(tbl[i], e, rd, h, lat);
      x = sb.pop_front();
      checks++;
      if (e !== x.err || lat != x.lat || ((x.op == 3 || x.op == 4) && rd !== x.rd) || (x.op == 0 && h !== x.h)) begin
        errors++;
        $display("FAIL basic step %0d op=%0d: err=%b rdata=%0d handle=%0d lat=%0d, want err=%b rdata=%0d handle=%0d lat=%0d",
                 i, x.op, e, rd, h, lat, x.err, x.rd, x.h, x.lat);
      end
    end
    checks++;
    if (bus.in_use !== 2'd2 || bus.peak !== 2'd2) begin
      errors++;
      $display("FAIL basic_counts: in_use=%0d peak=%0d, want 2 2", bus.in_use, bus.peak);
    end
  endtask

  task automatic test_recycle;
    step_t tbl[$];
    step_t x;
    logic e; logic [WIDTH-1:0] rd; logic [AW-1:0] h; int lat;
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 1, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      run_req(tbl[i], e, rd, h, lat);
      x = sb.pop_front();
      checks++;
      if (e !== x.err || lat != x.lat || ((x.op == 3 || x.op == 4) && rd !== x.rd) || (x.op == 0 && h !== x.h)) begin
        errors++;
        $display("FAIL recycle step %0d op=%0d: err=%b rdata=%0d handle=%0d lat=%0d, want err=%b rdata=%0d handle=%0d lat=%0d",
                 i, x.op, e, rd, h, lat, x.err, x.rd, x.h, x.lat);
      end
    end
    checks++;
    if (bus.in_use !== 2'd2 || bus.peak !== 2'd2) begin
      errors++;
      $display("FAIL recycle_counts: in_use=%0d peak=%0d, want 2 2", bus.in_use, bus.peak);
    end
  endtask

  task automatic test_errors;
    step_t tbl[$];
    step_t x;
    logic e; logic [WIDTH-1:0] rd; logic [AW-1:0] h; int lat;
    tbl.push_back(mk(2, 0, 2, 5, 1, 0, 0));        // index == N_AREA
    tbl.push_back(mk(2, 0, 0, 7, 0, 0, 0));
    tbl.push_back(mk(3, 0, 1, 0, 1, 0, 0));        // index >= length
    tbl.push_back(mk(3, 0, 0, 0, 0, 7, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0));        // already free
    tbl.push_back(mk(6, 0, 0, 0, 1, 0, 0));        // illegal op
    tbl.push_back(mk(4, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(3, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(2, 0, 'h802, 99, 1, 0, 0));   // wide index, low bits alias slot 0
    tbl.push_back(mk(3, 0, 0, 0, 0, 7, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0, 1, 0));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      run_req(tbl[i], e, rd, h, lat);
      x = sb.pop_front();
      checks++;
      if (e !== x.err || lat != x.lat || ((x.op == 3 || x.op == 4) && rd !== x.rd) || (x.op == 0 && h !== x.h)) begin
        errors++;
        $display("FAIL errors step %0d op=%0d: err=%b rdata=%0d handle=%0d lat=%0d, want err=%b rdata=%0d handle=%0d lat=%0d",
                 i, x.op, e, rd, h, lat, x.err, x.rd, x.h, x.lat);
      end
    end
    checks++;
    if (bus.in_use !== 2'd1 || bus.peak !== 2'd2) begin
      errors++;
      $display("FAIL errors_counts: in_use=%0d peak=%0d, want 1 2", bus.in_use, bus.peak);
    end
  endtask

  // req held high: one request per done, spaced 3 cycles apart.
  task automatic test_back_to_back;
    step_t x;
    int gap;
    sb.push_back(mk(4, 0, 0, 0, 0, 1, 0));
    sb.push_back(mk(4, 0, 0, 0, 0, 1, 0));
    @(negedge clock);
    bus.req = 1'b1; bus.op = 3'd4; bus.array = '0; bus.index = '0;
    gap = 0;
    do begin @(posedge clock); #1; gap++; end while (bus.done !== 1'b1 && gap < 20);
    x = sb.pop_front();
    checks++;
    if (bus.done !== 1'b1 || bus.error !== x.err || bus.rdata !== x.rd) begin
      errors++;
      $display("FAIL b2b_first: done=%b err=%b rdata=%0d, want 1 %b %0d", bus.done, bus.error, bus.rdata, x.err, x.rd);
    end
    gap = 0;
    do begin @(posedge clock); #1; gap++; end while (bus.done !== 1'b1 && gap < 20);
    x = sb.pop_front();
    checks++;
    if (gap != 3 || bus.error !== x.err || bus.rdata !== x.rd) begin
      errors++;
      $display("FAIL b2b_spacing: gap=%0d err=%b rdata=%0d, want 3 %b %0d", gap, bus.error, bus.rdata, x.err, x.rd);
    end
    @(negedge clock);
    bus.req = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_reset_midop;
    step_t x;
    logic e; logic [WIDTH-1:0] rd; logic [AW-1:0] h; int lat;
    int seen;
    @(negedge clock);
    bus.req = 1'b1; bus.op = 3'd3; bus.array = '0; bus.index = '0;
    @(posedge clock); #1;
    bus.req = 1'b0;
    @(posedge clock); #2;               // now in RDWAIT
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL midop_busy: busy=%b, want 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.in_use !== '0 || bus.peak !== '0) begin
      errors++;
      $display("FAIL midop_async_reset: busy=%b done=%b in_use=%0d peak=%0d, want 0 0 0 0",
               bus.busy, bus.done, bus.in_use, bus.peak);
    end
    seen = 0;
    repeat (2) begin @(posedge clock); #1; if (bus.done === 1'b1) seen++; end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin @(posedge clock); #1; if (bus.done === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midop_no_done: done pulses=%0d, want 0", seen);
    end
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    run_req(mk(0, 0, 0, 0, 0, 0, 0), e, rd, h, lat);
    x = sb.pop_front();
    checks++;
    if (e !== x.err || h !== x.h || lat != x.lat || bus.in_use !== 2'd1 || bus.peak !== 2'd1) begin
      errors++;
      $display("FAIL midop_realloc: err=%b handle=%0d lat=%0d in_use=%0d peak=%0d, want %b %0d %0d 1 1",
               e, h, lat, bus.in_use, bus.peak, x.err, x.h, x.lat);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_recycle;
    test_errors;
    test_back_to_back;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/heap_array_manager.md
Name: heap_array_manager

Overview:
- Parametrised heap-array manager for the test-program FPGA core.
- Owns the heap memory, per-array lengths, the freed-array stack and the allocation counter, so the program sequencer no longer handles them inline.
- Services one request at a time: alloc, free, write, read, size.
- Uses a request/done handshake with fixed latency and flags every illegal access with an error output.

Parameters:
WIDTH, 12, element and data width in bits
N_ARRAYS, 2, maximum number of arrays
N_AREA, 2, elements per array area
AW, $clog2(N_ARRAYS) (min 1), array-handle width (derived)
IW, $clog2(N_AREA) (min 1), element-index width (derived)

Ports:
clock  input  1  driving clock
reset  input  1  asynchronous, active-high reset
req  input  1  request strobe; sampled only when busy=0
op  input  3  0=ALLOC 1=FREE 2=WRITE 3=READ 4=SIZE; 5-7 are illegal
array  input  AW  target array handle (FREE/WRITE/READ/SIZE)
index  input  WIDTH  element index (WRITE/READ)
wdata  input  WIDTH  write data
busy  output  1  high while a request is in progress
done  output  1  one-cycle completion pulse
error  output  1  valid with done; the request was rejected
rdata  output  WIDTH  READ data, or SIZE result; valid with done
handle  output  AW  ALLOC result; valid with done
in_use  output  AW+1  arrays currently allocated
peak  output  AW+1  maximum in_use since reset

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- State on reset:
  - busy, done, error, rdata, handle, in_use and peak all 0.
  - FSM returns to IDLE.
  - Free stack emptied; fresh-allocation counter set to 0.
  - Allocated bitmap and every array length cleared.
  - Heap storage is not cleared.
- Reset mid-operation aborts the request: no done, and no memory, length or stack update.
- Heap storage: N_ARRAYS*N_AREA words, single-port, synchronous read. Element address = array*N_AREA + index.
- FSM states: IDLE, EXEC, RDWAIT, DONE. busy = (state != IDLE).
  - IDLE: if req=1 at edge N, latch op, array, index and wdata, then go to EXEC. req while busy is ignored.
  - EXEC (edge N+1): validate and perform the op. READ goes to RDWAIT; every other op goes to DONE.
  - RDWAIT (edge N+2): capture memory output into rdata, then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE on the next edge. error, rdata and handle hold until the next done.
- Latency: done appears 2 cycles after acceptance (3 for READ). Minimum request spacing is 3 cycles (4 for READ).
- ALLOC:
  - Source of the handle: pop the free stack if it is non-empty (LIFO). Otherwise use the fresh counter, then increment it.
  - If neither source is available: error=1 and handle=0.
  - On success: set the allocated bit, set length to 0, increment in_use, peak = max(peak, in_use).
- FREE:
  - array must be allocated, otherwise error=1 with no state change.
  - On success: clear the allocated bit, push the handle onto the free stack, decrement in_use.
  - The stack depth is N_ARRAYS, so it can never overflow.
- WRITE:
  - Error cases: array not allocated, or index >= N_AREA. On error there is no memory write.
  - On success: mem[addr] = wdata, and length = max(length, index+1).
- READ:
  - Error cases: array not allocated, or index >= length. On error rdata=0.
  - On success: rdata = mem[addr].
- SIZE:
  - rdata = length, zero-extended to WIDTH.
  - error=1 if the array is not allocated, with rdata=0.
- Illegal op (5-7) or array >= N_ARRAYS: error=1 and no state change.
- Widths and arithmetic:
  - The index comparison uses the full WIDTH value (no truncation before the compare).
  - Length is IW+1 bits, so N_AREA is representable.
  - in_use never wraps; errors prevent underflow and overflow.

Test Plan:
- Defaults (N_ARRAYS=2, N_AREA=2). ALLOC; WRITE a0[0]=11, a0[1]=22; ALLOC; WRITE a1[1]=33; READ a1[1], a0[0], a0[1].
  -> handles 0 and 1; reads return 33, 11, 22; SIZE a1 = 2; in_use=2, peak=2.
- A third ALLOC with both arrays allocated -> error=1, handle=0, in_use stays 2.
- FREE 1, FREE 0, then ALLOC twice -> handles 0 then 1 (LIFO); SIZE of each = 0.
- Error paths, each with unchanged state:
  - WRITE a0[2] -> error.
  - READ a0[1] when length=1 -> error, rdata=0.
  - FREE of an unallocated array -> error.
  - op=6 -> error.
- Timing:
  - WRITE accepted at edge N -> done high after edge N+2.
  - READ -> done after edge N+3.
  - req held high throughout -> the next request is accepted only after done falls.
- Reset asserted asynchronously during RDWAIT:
  - busy, done and in_use go to 0 immediately; no done pulse.
  - The next ALLOC returns handle 0.
